// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared opcodes, ALU op encodings and per-lane control struct
package issue_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRA  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

    typedef logic [2:0] imm_src_t;
    localparam imm_src_t IMM_I = 3'b000;

    typedef struct packed {
        alu_op_t  alu_op;
        logic     alu_src;
        imm_src_t imm_src;
        logic     reg_write;
        logic     illegal;
    } lane_ctrl_t;

    localparam lane_ctrl_t CTRL_NOP = '{
        alu_op:    ALU_ADD,
        alu_src:   1'b0,
        imm_src:   IMM_I,
        reg_write: 1'b0,
        illegal:   1'b0
    };

endpackage

// File: rtl/lane_decode.sv
// rtl/lane_decode.sv - combinational single-lane R/I-type ALU decode
module lane_decode
    import issue_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output lane_ctrl_t ctrl
);

    logic is_r;
    logic is_i;

    assign is_r = (op == OP_RTYPE);
    assign is_i = (op == OP_ITYPE);

    always_comb begin
        ctrl = CTRL_NOP;
        if (is_r || is_i) begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = is_i;
            ctrl.imm_src   = IMM_I;
            case (funct3)
                3'd0: ctrl.alu_op = (is_r && funct7) ? ALU_SUB : ALU_ADD;
                3'd1: ctrl.alu_op = ALU_SLL;
                3'd2: ctrl.alu_op = ALU_SLT;
                3'd3: ctrl.alu_op = ALU_SLTU;
                3'd4: ctrl.alu_op = ALU_XOR;
                3'd5: ctrl.alu_op = funct7 ? ALU_SRA : ALU_SRL;
                3'd6: ctrl.alu_op = ALU_OR;
                3'd7: ctrl.alu_op = ALU_AND;
                default: ctrl.alu_op = ALU_ADD;
            endcase
        end else begin
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multi_issue_control.sv
// rtl/multi_issue_control.sv - N-lane issue control with intra-bundle hazard splitting
module multi_issue_control
    import issue_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     valid_i,
    input  logic [7*LANES-1:0]   op_i,
    input  logic [3*LANES-1:0]   funct3_i,
    input  logic [LANES-1:0]     funct7_i,
    input  logic [5*LANES-1:0]   rd_i,
    input  logic [5*LANES-1:0]   rs1_i,
    input  logic [5*LANES-1:0]   rs2_i,
    input  logic                 trigger_i,
    output logic                 bundle_ack_o,
    output logic [LANES-1:0]     issue_o,
    output logic [4*LANES-1:0]   ALUControl_o,
    output logic [LANES-1:0]     ALUSrc_o,
    output logic [3*LANES-1:0]   ImmSrc_o,
    output logic [LANES-1:0]     RegWrite_o,
    output logic [LANES-1:0]     illegal_o,
    output logic [CNT_W-1:0]     split_cnt_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    lane_ctrl_t       ctrl [LANES];
    logic [4:0]       rd   [LANES];
    logic [4:0]       rs1  [LANES];
    logic [4:0]       rs2  [LANES];
    logic [LANES-1:0] is_r;

    logic [LANES-1:0] pend;
    logic [LANES-1:0] cand;
    logic [LANES-1:0] grp;
    logic [LANES-1:0] rest;
    logic [LANES-1:0] issue;
    logic             blocked;
    logic             hazard;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_decode u_lane_decode (
            .op     (op_i[7*k +: 7]),
            .funct3 (funct3_i[3*k +: 3]),
            .funct7 (funct7_i[k]),
            .ctrl   (ctrl[k])
        );
        assign rd[k]   = rd_i[5*k +: 5];
        assign rs1[k]  = rs1_i[5*k +: 5];
        assign rs2[k]  = rs2_i[5*k +: 5];
        assign is_r[k] = (op_i[7*k +: 7] == OP_RTYPE);
    end

    // Grow the issue group oldest-first; the first lane that depends on a
    // lane already in the group closes it, so the first candidate always goes.
    always_comb begin
        cand    = (pend == '0) ? valid_i : pend;
        grp     = '0;
        blocked = 1'b0;
        hazard  = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            hazard = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (i < j && grp[i] && ctrl[i].reg_write && rd[i] != '0 &&
                    (rd[i] == rs1[j] || (is_r[j] && rd[i] == rs2[j]) || rd[i] == rd[j])) begin
                    hazard = 1'b1;
                end
            end
            if (cand[j] && !blocked) begin
                if (hazard) begin
                    blocked = 1'b1;
                end else begin
                    grp[j] = 1'b1;
                end
            end
        end
    end

    assign rest         = cand & ~grp;
    assign issue        = trigger_i ? '0 : grp;
    assign bundle_ack_o = !trigger_i && (rest == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            issue_o      <= '0;
            ALUControl_o <= '0;
            ALUSrc_o     <= '0;
            ImmSrc_o     <= '0;
            RegWrite_o   <= '0;
            illegal_o    <= '0;
            split_cnt_o  <= '0;
            stall_cnt_o  <= '0;
        end else begin
            issue_o <= issue;
            for (int k = 0; k < LANES; k++) begin
                ALUControl_o[4*k +: 4] <= issue[k] ? ctrl[k].alu_op : ALU_ADD;
                ALUSrc_o[k]            <= issue[k] && ctrl[k].alu_src;
                ImmSrc_o[3*k +: 3]     <= issue[k] ? ctrl[k].imm_src : IMM_I;
                RegWrite_o[k]          <= issue[k] && ctrl[k].reg_write;
                illegal_o[k]           <= issue[k] && ctrl[k].illegal;
            end
            if (trigger_i) begin
                if (stall_cnt_o != '1) begin
                    stall_cnt_o <= stall_cnt_o + CNT_W'(1);
                end
            end else begin
                pend <= rest;
                if (pend == '0 && rest != '0 && split_cnt_o != '1) begin
                    split_cnt_o <= split_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_issue_control.sv
// tb/tb_multi_issue_control.sv - table, directed reset and randomized model checks
module tb_multi_issue_control;

    localparam int L  = 4;
    localparam int CW = 16;
    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;

    logic             clk = 1'b0;
    logic             rst;
    logic [L-1:0]     valid;
    logic [7*L-1:0]   op;
    logic [3*L-1:0]   f3;
    logic [L-1:0]     f7;
    logic [5*L-1:0]   rd, rs1, rs2;
    logic             trig;
    logic             ack;
    logic [L-1:0]     iss, src, wr, ill;
    logic [4*L-1:0]   alu;
    logic [3*L-1:0]   imm;
    logic [CW-1:0]    split, stall;

    int n_chk  = 0;
    int n_fail = 0;

    multi_issue_control #(.LANES(L), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid),
        .op_i         (op),
        .funct3_i     (f3),
        .funct7_i     (f7),
        .rd_i         (rd),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .trigger_i    (trig),
        .bundle_ack_o (ack),
        .issue_o      (iss),
        .ALUControl_o (alu),
        .ALUSrc_o     (src),
        .ImmSrc_o     (imm),
        .RegWrite_o   (wr),
        .illegal_o    (ill),
        .split_cnt_o  (split),
        .stall_cnt_o  (stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ins_t;

    typedef struct {
        logic [L-1:0]     v;
        ins_t [L-1:0]     l;
        logic             t;
        logic             ack;
        logic [L-1:0]     iss;
        logic [4*L-1:0]   alu;
        logic [L-1:0]     src;
        logic [L-1:0]     wr;
        logic [L-1:0]     ill;
        int               split;
        int               stall;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        ins_t x;
        x.op = o; x.f3 = fn3; x.f7 = fn7; x.rd = d; x.rs1 = s1; x.rs2 = s2;
        return x;
    endfunction

    function automatic vec_t mkv(input logic [L-1:0] v, input ins_t a0, input ins_t a1,
                                 input ins_t a2, input ins_t a3, input logic t, input logic e_ack,
                                 input logic [L-1:0] e_iss, input logic [4*L-1:0] e_alu,
                                 input logic [L-1:0] e_src, input logic [L-1:0] e_wr,
                                 input logic [L-1:0] e_ill, input int e_split, input int e_stall);
        vec_t x;
        x.v = v; x.l = {a3, a2, a1, a0}; x.t = t; x.ack = e_ack; x.iss = e_iss; x.alu = e_alu;
        x.src = e_src; x.wr = e_wr; x.ill = e_ill; x.split = e_split; x.stall = e_stall;
        return x;
    endfunction

    task automatic drive(input logic [L-1:0] v, input ins_t [L-1:0] l, input logic t);
        valid = v;
        trig  = t;
        for (int k = 0; k < L; k++) begin
            op[7*k +: 7]  = l[k].op;
            f3[3*k +: 3]  = l[k].f3;
            f7[k]         = l[k].f7;
            rd[5*k +: 5]  = l[k].rd;
            rs1[5*k +: 5] = l[k].rs1;
            rs2[5*k +: 5] = l[k].rs2;
        end
    endtask

    // Reference model: bundle as an ordered list of candidate lanes.
    logic [3:0]   alu_tab [8];
    logic [L-1:0] m_p;
    int           m_split, m_stall;

    function automatic logic lane_is_r(input int k);
        return op[7*k +: 7] == R_OP;
    endfunction

    function automatic logic lane_legal(input int k);
        return op[7*k +: 7] == R_OP || op[7*k +: 7] == I_OP;
    endfunction

    function automatic logic [3:0] lane_alu(input int k);
        logic [2:0] fn;
        fn = f3[3*k +: 3];
        if (!lane_legal(k)) return 4'h0;
        if (fn == 3'd0 && lane_is_r(k) && f7[k]) return 4'h1;
        if (fn == 3'd5 && f7[k]) return 4'h6;
        return alu_tab[fn];
    endfunction

    function automatic logic [L-1:0] model_group(input logic [L-1:0] c);
        int           q[$];
        logic [L-1:0] g;
        logic         conflict;
        int           a, b;
        g = '0;
        for (int k = 0; k < L; k++) if (c[k]) q.push_back(k);
        for (int n = 0; n < q.size(); n++) begin
            conflict = 1'b0;
            b = q[n];
            for (int m = 0; m < n; m++) begin
                a = q[m];
                if (lane_legal(a) && rd[5*a +: 5] != 5'd0 &&
                    (rd[5*a +: 5] == rs1[5*b +: 5] || rd[5*a +: 5] == rd[5*b +: 5] ||
                     (lane_is_r(b) && rd[5*a +: 5] == rs2[5*b +: 5])))
                    conflict = 1'b1;
            end
            if (conflict) break;
            g[b] = 1'b1;
        end
        return g;
    endfunction

    task automatic apply_vec(input vec_t x, input int idx);
        string s;
        drive(x.v, x.l, x.t);
        s = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({s, "_ack"}, ack, x.ack);
        @(posedge clk); #1;
        chk({s, "_issue"}, iss, x.iss);
        chk({s, "_alu"}, alu, x.alu);
        chk({s, "_alusrc"}, src, x.src);
        chk({s, "_immsrc"}, imm, '0);
        chk({s, "_regwrite"}, wr, x.wr);
        chk({s, "_illegal"}, ill, x.ill);
        chk({s, "_split"}, split, x.split);
        chk({s, "_stall"}, stall, x.stall);
    endtask

    task automatic random_step(input int n);
        logic [L-1:0]   c, g, e_iss, e_src, e_wr, e_ill;
        logic [4*L-1:0] e_alu;
        logic           e_ack;
        c     = (m_p == '0) ? valid : m_p;
        g     = trig ? '0 : model_group(c);
        e_ack = !trig && (g == c);
        e_alu = '0; e_src = '0; e_wr = '0; e_ill = '0;
        for (int k = 0; k < L; k++) begin
            if (g[k]) begin
                e_alu[4*k +: 4] = lane_alu(k);
                e_src[k]        = op[7*k +: 7] == I_OP;
                e_wr[k]         = lane_legal(k);
                e_ill[k]        = !lane_legal(k);
            end
        end
        e_iss = g;
        @(negedge clk);
        chk($sformatf("rnd%0d_ack", n), ack, e_ack);
        if (trig) begin
            m_stall++;
        end else begin
            if (m_p == '0 && (c & ~g) != '0) m_split++;
            m_p = c & ~g;
        end
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_issue", n), iss, e_iss);
        chk($sformatf("rnd%0d_alu", n), alu, e_alu);
        chk($sformatf("rnd%0d_alusrc", n), src, e_src);
        chk($sformatf("rnd%0d_immsrc", n), imm, '0);
        chk($sformatf("rnd%0d_regwrite", n), wr, e_wr);
        chk($sformatf("rnd%0d_illegal", n), ill, e_ill);
        chk($sformatf("rnd%0d_split", n), split, m_split);
        chk($sformatf("rnd%0d_stall", n), stall, m_stall);
    endtask

    initial begin
        ins_t x0, add1, addi4, sub6, c1, c2, c3, ld5, srai7, add0, add3z, waw0, waw1, add9;
        ins_t [L-1:0] rl;
        ins_t [L-1:0] tmp;
        logic [L-1:0] rv;
        int r;

        alu_tab = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h7, 4'h3, 4'h2};
        rst = 1'b1;
        x0  = mk(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive('0, {x0, x0, x0, x0}, 1'b0);

        add1  = mk(R_OP,  3'd0, 1'b0, 5'd1, 5'd2, 5'd3);
        addi4 = mk(I_OP,  3'd0, 1'b0, 5'd4, 5'd5, 5'd7);
        sub6  = mk(R_OP,  3'd0, 1'b1, 5'd6, 5'd1, 5'd4);
        c1    = mk(R_OP,  3'd0, 1'b0, 5'd2, 5'd1, 5'd0);
        c2    = mk(R_OP,  3'd0, 1'b0, 5'd3, 5'd2, 5'd0);
        c3    = mk(R_OP,  3'd0, 1'b0, 5'd4, 5'd3, 5'd0);
        ld5   = mk(LD_OP, 3'd2, 1'b0, 5'd5, 5'd6, 5'd0);
        srai7 = mk(I_OP,  3'd5, 1'b1, 5'd7, 5'd5, 5'd3);
        add0  = mk(R_OP,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2);
        add3z = mk(R_OP,  3'd0, 1'b0, 5'd3, 5'd0, 5'd0);
        waw0  = mk(R_OP,  3'd0, 1'b0, 5'd5, 5'd1, 5'd2);
        waw1  = mk(I_OP,  3'd0, 1'b0, 5'd5, 5'd3, 5'd1);
        add9  = mk(R_OP,  3'd0, 1'b0, 5'd9, 5'd8, 5'd8);

        //                 valid  lanes 0..3                  trig ack  iss    alu       src    wr     ill  split stall
        tab.push_back(mkv(4'b0011, add1,  addi4, x0, x0, 1'b0, 1'b1, 4'b0011, 16'h0000, 4'b0010, 4'b0011, 4'b0000, 0, 0));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b0, 1'b0, 4'b0001, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 1, 0));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b0, 1'b1, 4'b0010, 16'h0010, 4'b0000, 4'b0010, 4'b0000, 1, 0));
        tab.push_back(mkv(4'b1111, add1,  c1,    c2, c3, 1'b0, 1'b0, 4'b0001, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 2, 0));
        tab.push_back(mkv(4'b1111, add1,  c1,    c2, c3, 1'b0, 1'b0, 4'b0010, 16'h0000, 4'b0000, 4'b0010, 4'b0000, 2, 0));
        tab.push_back(mkv(4'b1111, add1,  c1,    c2, c3, 1'b0, 1'b0, 4'b0100, 16'h0000, 4'b0000, 4'b0100, 4'b0000, 2, 0));
        tab.push_back(mkv(4'b1111, add1,  c1,    c2, c3, 1'b0, 1'b1, 4'b1000, 16'h0000, 4'b0000, 4'b1000, 4'b0000, 2, 0));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b0, 1'b0, 4'b0001, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 3, 0));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b1, 1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 3, 1));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b1, 1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 3, 2));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b1, 1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 3, 3));
        tab.push_back(mkv(4'b0011, add1,  sub6,  x0, x0, 1'b0, 1'b1, 4'b0010, 16'h0010, 4'b0000, 4'b0010, 4'b0000, 3, 3));
        tab.push_back(mkv(4'b0011, ld5,   srai7, x0, x0, 1'b0, 1'b1, 4'b0011, 16'h0060, 4'b0010, 4'b0010, 4'b0001, 3, 3));
        tab.push_back(mkv(4'b0011, add0,  add3z, x0, x0, 1'b0, 1'b1, 4'b0011, 16'h0000, 4'b0000, 4'b0011, 4'b0000, 3, 3));
        tab.push_back(mkv(4'b0011, waw0,  waw1,  x0, x0, 1'b0, 1'b0, 4'b0001, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 4, 3));
        tab.push_back(mkv(4'b0011, waw0,  waw1,  x0, x0, 1'b0, 1'b1, 4'b0010, 16'h0000, 4'b0010, 4'b0010, 4'b0000, 4, 3));
        tab.push_back(mkv(4'b0000, x0,    x0,    x0, x0, 1'b0, 1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4, 3));
        tab.push_back(mkv(4'b0001, add1,  x0,    x0, x0, 1'b1, 1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 4, 4));
        tab.push_back(mkv(4'b0001, add1,  x0,    x0, x0, 1'b0, 1'b1, 4'b0001, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 4, 4));

        #12;
        chk("reset_issue", iss, '0);
        chk("reset_regwrite", wr, '0);
        chk("reset_split", split, '0);
        chk("reset_stall", stall, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) apply_vec(tab[i], i);

        // Asynchronous reset mid-split, then a fresh bundle must ignore the old pending lane.
        tmp = {x0, x0, sub6, add1};
        drive(4'b0011, tmp, 1'b0);
        @(posedge clk); #1;
        chk("split_before_rst_issue", iss, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_issue", iss, '0);
        chk("async_rst_regwrite", wr, '0);
        chk("async_rst_alu", alu, '0);
        chk("async_rst_split", split, '0);
        chk("async_rst_stall", stall, '0);
        #1 rst = 1'b0;
        tmp = {x0, add9, x0, x0};
        drive(4'b0100, tmp, 1'b0);
        @(negedge clk);
        chk("post_rst_ack", ack, 1'b1);
        @(posedge clk); #1;
        chk("post_rst_issue", iss, 4'b0100);
        chk("post_rst_split", split, '0);

        // Randomized traffic against the list-based model.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_p = '0; m_split = 0; m_stall = 0;
        rv = '0;
        rl = {x0, x0, x0, x0};
        for (int n = 0; n < 400; n++) begin
            if (m_p == '0) begin
                rv = L'($urandom);
                for (int k = 0; k < L; k++) begin
                    r = $urandom_range(0, 11);
                    rl[k] = mk((r < 6) ? R_OP : (r < 10) ? I_OP : LD_OP,
                               3'($urandom), 1'($urandom),
                               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                               5'($urandom_range(0, 3)));
                end
            end
            drive(rv, rl, $urandom_range(0, 4) == 0);
            random_step(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
